fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the load-use hazard unit.
- Owns the PC and a single-outstanding-request instruction-memory handshake.
- Consumes the hazard unit's stall and the EX-stage branch flush.
- Produces the IF/ID register, including the decoded Rs1/Rs2/Rd fields the hazard unit compares.

Parameters:
- RESET_PC, 32'h00000000, PC fetched first after reset.
- NOP_INST, 32'h00000013, encoding loaded into IF/ID on reset, bubble or flush (addi x0,x0,0).

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  load-use stall from hazard unit; freezes PC and IF/ID.
- flush  in  1  taken branch/jump resolved downstream; squashes IF/ID and redirects PC.
- branch_target  in  32  new PC, sampled when flush=1.
- imem_req  out  1  fetch request; held high until response.
- imem_addr  out  32  fetch address; equals PC register; stable while imem_req=1.
- imem_valid  in  1  one-cycle response strobe; never in the same cycle as a new request's first cycle.
- imem_rdata  in  32  instruction, valid with imem_valid.
- IF_ID_PC  out  32  PC of instruction in IF/ID.
- IF_ID_Inst  out  32  instruction in IF/ID.
- IF_ID_Valid  out  1  IF/ID holds a real instruction.
- IF_ID_Rs1  out  5  IF_ID_Inst[19:15], combinational from the register.
- IF_ID_Rs2  out  5  IF_ID_Inst[24:20].
- IF_ID_Rd  out  5  IF_ID_Inst[11:7].

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - PC=RESET_PC, IF_ID_PC=0, IF_ID_Inst=NOP_INST, IF_ID_Valid=0.
  - Buffer empty, state=WAIT.
  - imem_req=0 while rst=1.
- Reset mid-request: any in-flight response is discarded by the memory side; the stage does not track it.
- FSM states:
  - WAIT: request outstanding; imem_req=1.
  - HOLD: response buffered during stall; imem_req=0.
  - DROP: stale response pending after flush; imem_req=0.
- WAIT, imem_valid=1, flush=0, stall=0:
  - IF/ID <= {PC, imem_rdata, valid=1}; PC <= PC+4.
  - Stay WAIT, so back-to-back requests occur with no idle cycle.
- WAIT, imem_valid=1, flush=0, stall=1:
  - Buffer <= {PC, imem_rdata}; PC <= PC+4; IF/ID unchanged; go HOLD.
- WAIT, imem_valid=0, stall=0, flush=0:
  - IF/ID <= bubble (NOP_INST, valid=0, PC=0). IF/ID advances every non-stalled cycle.
- HOLD, stall=0, flush=0:
  - IF/ID <= buffer with valid=1; buffer cleared; go WAIT.
  - New request to the already-incremented PC starts next cycle.
- HOLD, stall=1: hold everything.
- flush=1 (priority over stall, any state):
  - IF/ID <= bubble; buffer cleared; PC <= branch_target.
  - From WAIT with imem_valid=0: go DROP.
  - From WAIT with imem_valid=1 in the same cycle: response discarded; go WAIT.
  - From HOLD: go WAIT.
  - From DROP: update PC; stay DROP.
- DROP:
  - imem_valid=1 and flush=0: response discarded; go WAIT.
  - imem_valid=1 and flush=1: PC <= branch_target, response discarded; go WAIT.
- PC arithmetic: PC+4 wraps modulo 2^32 (32'hFFFFFFFC -> 0); no fault.
- Bubbles: IF/ID bubble always carries NOP_INST, so Rs1/Rs2/Rd=0 and the downstream x0 check suppresses false stalls.
- Address ordering:
  - imem_addr changes only when imem_req=0 or in the cycle after a consumed response.
  - Never change it mid-request.

Test Plan:
- Reset, then memory answers 1 cycle after each request with addr-tagged data -> IF/ID shows PCs 0,4,8 on consecutive response cycles with Valid=1, imem_req continuously high.
- Response for PC=8 with stall=1 for 3 cycles -> IF/ID holds PC=4, imem_req=0, state HOLD; stall drops -> IF/ID={8,data,1} next edge, then imem_addr=12.
- flush=1, branch_target=0x100 while request to 0x10 outstanding -> IF/ID bubble; imem_req=0 until stale response arrives; stale data never appears in IF/ID; next imem_addr=0x100.
- flush and imem_valid in same cycle, target 0x200 -> response dropped, imem_req=1 with addr 0x200 next cycle, no DROP state.
- flush and stall both 1 in HOLD -> flush wins: buffer cleared, IF/ID bubble with IF_ID_Rs1=Rs2=0, PC=target.
- PC=0xFFFFFFFC accepted -> next imem_addr=0x00000000; rst asserted mid-WAIT -> next edge IF_ID_Valid=0, PC=RESET_PC, imem_req=0 during reset.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC and a single-outstanding-request instruction-memory handshake.
// A response that arrives while decode is stalled is parked in a one-entry
// buffer (HOLD). A response still in flight when a redirect happens is
// swallowed (DROP), so the stage never has two requests outstanding.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_Inst,
    output logic        IF_ID_Valid,
    output logic [4:0]  IF_ID_Rs1,
    output logic [4:0]  IF_ID_Rs2,
    output logic [4:0]  IF_ID_Rd
);

    // WAIT: request outstanding. HOLD: response parked behind a stall.
    // DROP: a response for a squashed fetch is still on its way.
    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic        buf_valid_q, buf_valid_d;

    logic [31:0] pc_plus4;

    // Wraps modulo 2^32 naturally; running off the top of memory is not a fault.
    assign pc_plus4 = pc_q + 32'd4;

    // Next-state logic: flush outranks stall, stall freezes PC and IF/ID.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_valid_d = ifid_valid_q;
        buf_pc_d     = buf_pc_q;
        buf_inst_d   = buf_inst_q;
        buf_valid_d  = buf_valid_q;

        if (flush) begin
            // Squash decode, forget any parked response, redirect the PC.
            ifid_pc_d    = 32'd0;
            ifid_inst_d  = NOP_INST;
            ifid_valid_d = 1'b0;
            buf_pc_d     = 32'd0;
            buf_inst_d   = NOP_INST;
            buf_valid_d  = 1'b0;
            pc_d         = branch_target;
            unique case (state_q)
                // A response landing this very cycle is consumed and discarded,
                // so the new request can start immediately; otherwise the old
                // response is still coming and must be swallowed first.
                S_WAIT:  state_d = imem_valid ? S_WAIT : S_DROP;
                S_HOLD:  state_d = S_WAIT;
                S_DROP:  state_d = imem_valid ? S_WAIT : S_DROP;
                default: state_d = S_WAIT;
            endcase
        end else begin
            unique case (state_q)
                S_WAIT: begin
                    if (imem_valid) begin
                        pc_d = pc_plus4;
                        if (stall) begin
                            // Decode is frozen: park the instruction.
                            buf_pc_d    = pc_q;
                            buf_inst_d  = imem_rdata;
                            buf_valid_d = 1'b1;
                            state_d     = S_HOLD;
                        end else begin
                            ifid_pc_d    = pc_q;
                            ifid_inst_d  = imem_rdata;
                            ifid_valid_d = 1'b1;
                        end
                    end else if (!stall) begin
                        ifid_pc_d    = 32'd0;
                        ifid_inst_d  = NOP_INST;
                        ifid_valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        // Release the parked instruction; PC already points past it.
                        ifid_pc_d    = buf_pc_q;
                        ifid_inst_d  = buf_inst_q;
                        ifid_valid_d = 1'b1;
                        buf_pc_d     = 32'd0;
                        buf_inst_d   = NOP_INST;
                        buf_valid_d  = 1'b0;
                        state_d      = S_WAIT;
                    end
                end
                S_DROP: begin
                    if (!stall) begin
                        ifid_pc_d    = 32'd0;
                        ifid_inst_d  = NOP_INST;
                        ifid_valid_d = 1'b0;
                    end
                    if (imem_valid) begin
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_WAIT;
            endcase
        end

        req_d = (state_d == S_WAIT);
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_WAIT;
            req_q        <= 1'b1;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'd0;
            ifid_inst_q  <= NOP_INST;
            ifid_valid_q <= 1'b0;
            buf_pc_q     <= 32'd0;
            buf_inst_q   <= NOP_INST;
            buf_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_valid_q <= ifid_valid_d;
            buf_pc_q     <= buf_pc_d;
            buf_inst_q   <= buf_inst_d;
            buf_valid_q  <= buf_valid_d;
        end
    end

    // Request is registered from the next state; masked while reset is held
    // so nothing is issued before the PC is known.
    assign imem_req  = req_q & ~rst;
    assign imem_addr = pc_q;

    assign IF_ID_PC    = ifid_pc_q;
    assign IF_ID_Inst  = ifid_inst_q;
    assign IF_ID_Valid = ifid_valid_q;

    // Register fields for the hazard unit; bubbles decode to x0 everywhere.
    assign IF_ID_Rs1 = ifid_inst_q[19:15];
    assign IF_ID_Rs2 = ifid_inst_q[24:20];
    assign IF_ID_Rd  = ifid_inst_q[11:7];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage: one table row per clock cycle.
module tb_fetch_stage;

    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] STALE = 32'hDEADBEEF;
    localparam logic [31:0] D0    = 32'h002081B3;
    localparam logic [31:0] D4    = 32'h00418233;
    localparam logic [31:0] D8    = 32'h40B50533;
    localparam logic [31:0] D12   = 32'h00C58613;
    localparam logic [31:0] D100  = 32'h01F00F93;
    localparam logic [31:0] D200  = 32'h00A28293;
    localparam logic [31:0] D204  = 32'h00B30313;
    localparam logic [31:0] D300  = 32'h00C38393;
    localparam logic [31:0] D600  = 32'h00D40413;
    localparam logic [31:0] DFFC  = 32'h00E48493;
    localparam logic [31:0] DW0   = 32'h00F50513;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_Inst;
    logic        IF_ID_Valid;
    logic [4:0]  IF_ID_Rs1;
    logic [4:0]  IF_ID_Rs2;
    logic [4:0]  IF_ID_Rd;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_rdata   (imem_rdata),
        .IF_ID_PC     (IF_ID_PC),
        .IF_ID_Inst   (IF_ID_Inst),
        .IF_ID_Valid  (IF_ID_Valid),
        .IF_ID_Rs1    (IF_ID_Rs1),
        .IF_ID_Rs2    (IF_ID_Rs2),
        .IF_ID_Rd     (IF_ID_Rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        valid;
        logic [31:0] target;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic f, input logic v,
                                input logic [31:0] tgt, input logic [31:0] rd,
                                input logic ereq, input logic [31:0] eaddr,
                                input logic [31:0] epc, input logic [31:0] einst,
                                input logic evalid);
        vec_t r;
        r.stall = s; r.flush = f; r.valid = v; r.target = tgt; r.rdata = rd;
        r.exp_req = ereq; r.exp_addr = eaddr; r.exp_pc = epc;
        r.exp_inst = einst; r.exp_valid = evalid;
        return r;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_ifid(input int idx, input logic [31:0] epc,
                              input logic [31:0] einst, input logic evalid);
        check("if_id_pc", idx, IF_ID_PC, epc);
        check("if_id_inst", idx, IF_ID_Inst, einst);
        check("if_id_valid", idx, {31'd0, IF_ID_Valid}, {31'd0, evalid});
        check("rs1", idx, {27'd0, IF_ID_Rs1}, {27'd0, einst[19:15]});
        check("rs2", idx, {27'd0, IF_ID_Rs2}, {27'd0, einst[24:20]});
        check("rd", idx, {27'd0, IF_ID_Rd}, {27'd0, einst[11:7]});
    endtask

    initial begin
        // stall flush valid target rdata | req addr if_pc if_inst if_valid
        vecs.push_back(mk(0,0,0, 0, 0,      1, 32'h0,   0, NOP, 0));   // first request cycle
        vecs.push_back(mk(0,0,1, 0, D0,     1, 32'h4,   0, D0,  1));
        vecs.push_back(mk(0,0,0, 0, 0,      1, 32'h4,   0, NOP, 0));
        vecs.push_back(mk(0,0,1, 0, D4,     1, 32'h8,   4, D4,  1));
        vecs.push_back(mk(1,0,0, 0, 0,      1, 32'h8,   4, D4,  1));   // stall, no response
        vecs.push_back(mk(1,0,1, 0, D8,     0, 32'hC,   4, D4,  1));   // response parked -> HOLD
        vecs.push_back(mk(1,0,0, 0, 0,      0, 32'hC,   4, D4,  1));
        vecs.push_back(mk(0,0,0, 0, 0,      1, 32'hC,   8, D8,  1));   // release buffer
        vecs.push_back(mk(0,0,0, 0, 0,      1, 32'hC,   0, NOP, 0));
        vecs.push_back(mk(0,0,1, 0, D12,    1, 32'h10, 12, D12, 1));
        vecs.push_back(mk(0,1,0, 32'h100, 0,     0, 32'h100, 0, NOP, 0)); // flush -> DROP
        vecs.push_back(mk(0,0,0, 0, 0,      0, 32'h100, 0, NOP, 0));
        vecs.push_back(mk(0,0,1, 0, STALE,  1, 32'h100, 0, NOP, 0));   // stale swallowed
        vecs.push_back(mk(0,0,0, 0, 0,      1, 32'h100, 0, NOP, 0));
        vecs.push_back(mk(0,0,1, 0, D100,   1, 32'h104, 32'h100, D100, 1));
        vecs.push_back(mk(0,0,0, 0, 0,      1, 32'h104, 0, NOP, 0));
        vecs.push_back(mk(0,1,1, 32'h200, STALE, 1, 32'h200, 0, NOP, 0)); // flush + response
        vecs.push_back(mk(0,0,0, 0, 0,      1, 32'h200, 0, NOP, 0));
        vecs.push_back(mk(0,0,1, 0, D200,   1, 32'h204, 32'h200, D200, 1));
        vecs.push_back(mk(1,0,0, 0, 0,      1, 32'h204, 32'h200, D200, 1));
        vecs.push_back(mk(1,0,1, 0, D204,   0, 32'h208, 32'h200, D200, 1)); // HOLD
        vecs.push_back(mk(1,1,0, 32'h300, 0,     1, 32'h300, 0, NOP, 0)); // flush beats stall
        vecs.push_back(mk(0,0,0, 0, 0,      1, 32'h300, 0, NOP, 0));
        vecs.push_back(mk(0,0,1, 0, D300,   1, 32'h304, 32'h300, D300, 1));
        vecs.push_back(mk(0,1,0, 32'h400, 0,     0, 32'h400, 0, NOP, 0)); // -> DROP
        vecs.push_back(mk(0,1,0, 32'h500, 0,     0, 32'h500, 0, NOP, 0)); // flush in DROP
        vecs.push_back(mk(0,1,1, 32'h600, STALE, 1, 32'h600, 0, NOP, 0)); // DROP + flush + resp
        vecs.push_back(mk(0,0,0, 0, 0,      1, 32'h600, 0, NOP, 0));
        vecs.push_back(mk(0,0,1, 0, D600,   1, 32'h604, 32'h600, D600, 1));
        vecs.push_back(mk(0,1,0, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 0, NOP, 0));
        vecs.push_back(mk(0,0,1, 0, STALE,  1, 32'hFFFFFFFC, 0, NOP, 0));
        vecs.push_back(mk(0,0,0, 0, 0,      1, 32'hFFFFFFFC, 0, NOP, 0));
        vecs.push_back(mk(0,0,1, 0, DFFC,   1, 32'h0, 32'hFFFFFFFC, DFFC, 1)); // wrap
        vecs.push_back(mk(0,0,0, 0, 0,      1, 32'h0, 0, NOP, 0));
        vecs.push_back(mk(0,0,1, 0, DW0,    1, 32'h4, 0, DW0, 1));

        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = 32'd0;
        imem_valid = 1'b0; imem_rdata = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_req", -1, {31'd0, imem_req}, 32'd0);
        check("reset_addr", -1, imem_addr, 32'h0);
        check_ifid(-1, 32'd0, NOP, 1'b0);
        rst = 1'b0;
        #1;
        check("post_reset_req", -1, {31'd0, imem_req}, 32'd1);
        check("post_reset_addr", -1, imem_addr, 32'h0);

        // Table-driven cycles
        for (int i = 0; i < vecs.size(); i++) begin
            stall         = vecs[i].stall;
            flush         = vecs[i].flush;
            imem_valid    = vecs[i].valid;
            branch_target = vecs[i].target;
            imem_rdata    = vecs[i].rdata;
            @(posedge clk);
            #1;
            check("imem_req", i, {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
            check("imem_addr", i, imem_addr, vecs[i].exp_addr);
            check_ifid(i, vecs[i].exp_pc, vecs[i].exp_inst, vecs[i].exp_valid);
        end

        // Reset in the middle of a WAIT with a valid instruction in IF/ID and PC=4
        stall = 1'b0; flush = 1'b0; imem_valid = 1'b0; imem_rdata = 32'd0;
        rst = 1'b1;
        #1;
        check("rst_req_low", 100, {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_req_low2", 101, {31'd0, imem_req}, 32'd0);
        check("rst_pc", 101, imem_addr, 32'h0);
        check_ifid(101, 32'd0, NOP, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_release_req", 102, {31'd0, imem_req}, 32'd1);
        @(posedge clk);
        #1;
        check_ifid(103, 32'd0, NOP, 1'b0);
        imem_valid = 1'b1; imem_rdata = D0;
        @(posedge clk);
        #1;
        check("restart_addr", 104, imem_addr, 32'h4);
        check_ifid(104, 32'd0, D0, 1'b1);
        imem_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
